rgb2hsv_seq: RTL and testbench
==============================

Name: rgb2hsv_seq

Overview:
- Sequential, parametrised RGB-to-HSV converter for the camera capture path. Sits between the YCbCr-to-RGB stage and the frame-buffer write logic.
- Replaces combinational max/min/divide with an exact shared iterative restoring divider behind valid/ready handshakes.
- Carries a sideband tag, such as a pixel address, alongside each pixel.

Parameters:
CW, 8, channel width of R, G, B, V and S
HFRAC, 5, fractional hue bits per 60-degree sector; H width = HFRAC+3; H range 0..6*2^HFRAC-1
TAGW, 16, sideband tag width

Ports:
Sys_clk  in  1  system clock; all state on rising edge
resetx  in  1  asynchronous active-low reset
in_valid  in  1  input pixel valid
in_ready  out  1  converter can accept a pixel
in_r / in_g / in_b  in  CW each  RGB components
in_tag  in  TAGW  sideband tag, passed through unchanged
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_h  out  HFRAC+3  hue
out_s  out  CW  saturation
out_v  out  CW  value
out_tag  out  TAGW  tag of this result

Behaviour:
- Clocking and reset: one clock (Sys_clk). Reset is asynchronous, active-low (resetx).
  - Reset values: state IDLE, in_ready=1, out_valid=0, out_h/out_s/out_v/out_tag=0.
  - Reset mid-operation aborts the pixel; no partial result is ever presented.
- FSM states: IDLE -> SORT -> DIV_S -> DIV_H -> DONE -> IDLE.
  - in_ready = (state==IDLE).
  - Accept: in_valid & in_ready at a rising edge. RGB and tag are registered, and the FSM goes to SORT.
  - SORT (1 cycle):
    - max uses tie priority R>G>B; min uses tie priority B>R>G; mid = the remaining channel.
    - delta = max-min; V = max.
    - Sector k: (max,min) = (R,B)->0, (G,B)->1, (G,R)->2, (B,R)->3, (B,G)->4, (R,G)->5.
  - DIV_S (CW+1 cycles): restoring division qs = floor(delta*2^CW / max).
    - S = min(qs, 2^CW-1).
    - If max==0 the divider is bypassed and S=0, but the cycle count is unchanged.
  - DIV_H (HFRAC+1 cycles): qh = floor((mid-min)*2^HFRAC / delta), range 0..2^HFRAC.
    - If delta==0, qh=0 and H=0, cycle count unchanged.
  - Hue assembly:
    - k even: H = k*2^HFRAC + qh.
    - k odd: H = (k+1)*2^HFRAC - qh.
    - If the result equals 6*2^HFRAC it wraps to 0.
  - DONE: out_valid=1; outputs and out_tag held stable until out_ready=1.
    - Transfer at out_valid & out_ready; next cycle is IDLE (out_valid=0, in_ready=1).
- Latency: fixed. out_valid rises CW+HFRAC+4 cycles after the accepting edge, independent of data.
  - Throughput is one pixel per CW+HFRAC+5 cycles when out_ready is held high.
- Divider: a single shared restoring divider (subtract/shift per cycle), no combinational '/' operator.
  - Numerator width CW+max(CW,HFRAC), divisor width CW.
- Backpressure: out_ready low in DONE holds all outputs. in_valid is ignored while in_ready=0; the upstream holds its data.
- Output registers change only on entry to DONE, and reset clears them.

Optional Feature:
- Macro: HSV_THRESH_EN.
- When defined:
  - Adds inputs th_h_lo, th_h_hi (HFRAC+3 each), th_s_min, th_v_min (CW each), and output out_mask (1), valid with out_valid.
  - out_mask = hue_in & (S>=th_s_min) & (V>=th_v_min).
  - hue_in = (lo<=H<=hi) when lo<=hi, else (H>=lo | H<=hi), covering a wrapped range through red.
  - The threshold inputs are sampled at accept.
  - out_mask resets to 0 and is held with the other outputs.
- When undefined: the ports and logic are absent, and the rest of the behaviour is identical.

Test Plan (CW=8, HFRAC=5, latency 17):
- Primary red: R=255,G=0,B=0, tag=0x1234 -> H=0, S=255 (qs=256 saturated), V=255, tag=0x1234, out_valid 17 cycles after accept.
- Primary green: R=0,G=255,B=0 -> H=64, S=255, V=255.
- Grey: R=G=B=100 -> H=0, S=0, V=100.
- Black: R=G=B=0 -> H=0, S=0, V=0, same latency.
- Mid-tone and red side:
  - R=200,G=150,B=100 -> H=16, S=128, V=200.
  - R=255,G=0,B=128 -> sector 5, qh=16, H=176, S=255.
- Handshake and reset:
  - out_ready held low 10 cycles -> outputs stable, in_ready=0, a second in_valid pixel is not accepted until after the transfer.
  - resetx low during DIV_S -> out_valid=0 and in_ready=1 immediately, and the next pixel converts correctly.
- HSV_THRESH_EN: lo=180, hi=10, s_min=100, v_min=50:
  - Red pixel -> mask=1.
  - Pixel with H=176 -> mask=0.
  - Grey pixel -> mask=0 (fails s_min).

Source files
------------

// File: rtl/rgb2hsv_seq.sv
// rtl/rgb2hsv_seq.sv - sequential RGB-to-HSV converter with a shared restoring divider; optional HSV_THRESH_EN adds a threshold mask
module rgb2hsv_seq #(
   parameter int CW    = 8,
   parameter int HFRAC = 5,
   parameter int TAGW  = 16
) (
   input  logic             Sys_clk,
   input  logic             resetx,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CW-1:0]    in_r,
   input  logic [CW-1:0]    in_g,
   input  logic [CW-1:0]    in_b,
   input  logic [TAGW-1:0]  in_tag,
`ifdef HSV_THRESH_EN
   input  logic [HFRAC+2:0] th_h_lo,
   input  logic [HFRAC+2:0] th_h_hi,
   input  logic [CW-1:0]    th_s_min,
   input  logic [CW-1:0]    th_v_min,
   output logic             out_mask,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [HFRAC+2:0] out_h,
   output logic [CW-1:0]    out_s,
   output logic [CW-1:0]    out_v,
   output logic [TAGW-1:0]  out_tag
);

   localparam int HW   = HFRAC + 3;
   localparam int MW   = (CW > HFRAC) ? CW : HFRAC;
   localparam int QW   = MW + 1;
   localparam int CNTW = $clog2(MW + 1);
   localparam logic [HW-1:0]   H_WRAP = HW'(6 * (2 ** HFRAC));
   localparam logic [CNTW-1:0] S_LAST = CNTW'(CW);
   localparam logic [CNTW-1:0] H_LAST = CNTW'(HFRAC);

   typedef enum logic [2:0] {IDLE, SORT, DIV_S, DIV_H, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   r_q, g_q, b_q;
   logic [TAGW-1:0] tag_q;
   logic [CW-1:0]   v_q, delta_q, diff_q, s_q;
   logic [2:0]      k_q;
   logic [CW:0]     rem_q;
   logic [CW-1:0]   div_q;
   logic [MW-1:0]   q_q;
   logic [CNTW-1:0] cnt_q;

   // channel indices: 0=R, 1=G, 2=B
   logic [1:0]      max_sel, min_sel, mid_sel;
   logic [CW-1:0]   max_c, min_c, mid_c;
   logic [2:0]      sector;

   logic            ge;
   logic [CW-1:0]   sub;
   logic [CW:0]     rem_step;
   logic [QW-1:0]   q_step;
   logic [CW-1:0]   s_calc;
   logic [HFRAC:0]  qh;
   logic [HW-1:0]   hue_raw, hue;

   assign in_ready = (state == IDLE);

   // rank the channels with the tie priorities and derive the hue sector
   always_comb begin
      if (r_q >= g_q && r_q >= b_q) max_sel = 2'd0;
      else if (g_q >= b_q)          max_sel = 2'd1;
      else                          max_sel = 2'd2;
      if (b_q <= r_q && b_q <= g_q) min_sel = 2'd2;
      else if (r_q <= g_q)          min_sel = 2'd0;
      else                          min_sel = 2'd1;
      mid_sel = 2'd3 - max_sel - min_sel;
      max_c = (max_sel == 2'd0) ? r_q : (max_sel == 2'd1) ? g_q : b_q;
      min_c = (min_sel == 2'd0) ? r_q : (min_sel == 2'd1) ? g_q : b_q;
      mid_c = (mid_sel == 2'd0) ? r_q : (mid_sel == 2'd1) ? g_q : b_q;
      case ({max_sel, min_sel})
         4'b00_10: sector = 3'd0;
         4'b01_10: sector = 3'd1;
         4'b01_00: sector = 3'd2;
         4'b10_00: sector = 3'd3;
         4'b10_01: sector = 3'd4;
         4'b00_01: sector = 3'd5;
         default:  sector = 3'd0;
      endcase
   end

   // one restoring-divider step; numerator low bits are all zero, so only zeros shift in
   always_comb begin
      ge       = (rem_q >= {1'b0, div_q});
      sub      = rem_q[CW-1:0] - div_q;
      rem_step = {(ge ? sub : rem_q[CW-1:0]), 1'b0};
      q_step   = {q_q, ge};
      // a zero divisor means max==0 or delta==0; both results are defined as zero
      if (div_q == '0)         s_calc = '0;
      else if (|q_step[QW-1:CW]) s_calc = '1;
      else                     s_calc = q_step[CW-1:0];
      qh = (div_q == '0) ? '0 : q_step[HFRAC:0];
      if (k_q[0]) hue_raw = {k_q + 3'd1, {HFRAC{1'b0}}} - {2'b00, qh};
      else        hue_raw = {k_q, {HFRAC{1'b0}}} + {2'b00, qh};
      hue = (hue_raw == H_WRAP) ? '0 : hue_raw;
   end

`ifdef HSV_THRESH_EN
   logic [HW-1:0] th_h_lo_q, th_h_hi_q;
   logic [CW-1:0] th_s_q, th_v_q;
   logic          hue_in, mask_calc;

   // hue window may wrap through red when lo > hi
   always_comb begin
      if (th_h_lo_q <= th_h_hi_q) hue_in = (hue >= th_h_lo_q) && (hue <= th_h_hi_q);
      else                        hue_in = (hue >= th_h_lo_q) || (hue <= th_h_hi_q);
      mask_calc = hue_in && (s_q >= th_s_q) && (v_q >= th_v_q);
   end
`endif

   // control FSM, datapath registers and registered outputs
   always_ff @(posedge Sys_clk or negedge resetx) begin
      if (!resetx) begin
         state     <= IDLE;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
         tag_q     <= '0;
         v_q       <= '0;
         delta_q   <= '0;
         diff_q    <= '0;
         s_q       <= '0;
         k_q       <= '0;
         rem_q     <= '0;
         div_q     <= '0;
         q_q       <= '0;
         cnt_q     <= '0;
         out_valid <= 1'b0;
         out_h     <= '0;
         out_s     <= '0;
         out_v     <= '0;
         out_tag   <= '0;
`ifdef HSV_THRESH_EN
         th_h_lo_q <= '0;
         th_h_hi_q <= '0;
         th_s_q    <= '0;
         th_v_q    <= '0;
         out_mask  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  r_q   <= in_r;
                  g_q   <= in_g;
                  b_q   <= in_b;
                  tag_q <= in_tag;
`ifdef HSV_THRESH_EN
                  th_h_lo_q <= th_h_lo;
                  th_h_hi_q <= th_h_hi;
                  th_s_q    <= th_s_min;
                  th_v_q    <= th_v_min;
`endif
                  state <= SORT;
               end
            end
            SORT: begin
               v_q     <= max_c;
               delta_q <= max_c - min_c;
               diff_q  <= mid_c - min_c;
               k_q     <= sector;
               rem_q   <= {1'b0, max_c - min_c};
               div_q   <= max_c;
               q_q     <= '0;
               cnt_q   <= '0;
               state   <= DIV_S;
            end
            DIV_S: begin
               if (cnt_q == S_LAST) begin
                  s_q   <= s_calc;
                  rem_q <= {1'b0, diff_q};
                  div_q <= delta_q;
                  q_q   <= '0;
                  cnt_q <= '0;
                  state <= DIV_H;
               end else begin
                  rem_q <= rem_step;
                  q_q   <= q_step[MW-1:0];
                  cnt_q <= cnt_q + CNTW'(1);
               end
            end
            DIV_H: begin
               if (cnt_q == H_LAST) begin
                  out_h     <= hue;
                  out_s     <= s_q;
                  out_v     <= v_q;
                  out_tag   <= tag_q;
`ifdef HSV_THRESH_EN
                  out_mask  <= mask_calc;
`endif
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  rem_q <= rem_step;
                  q_q   <= q_step[MW-1:0];
                  cnt_q <= cnt_q + CNTW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rgb2hsv_seq.sv
// tb/tb_rgb2hsv_seq.sv - randomized self-checking bench for rgb2hsv_seq against a behavioural HSV model
module tb_rgb2hsv_seq;
   localparam int CW     = 8;
   localparam int HFRAC  = 5;
   localparam int TAGW   = 16;
   localparam int HW     = HFRAC + 3;
   localparam int LAT    = CW + HFRAC + 4;
   localparam int PERIOD = CW + HFRAC + 5;

   logic            Sys_clk, resetx, in_valid, in_ready, out_valid, out_ready;
   logic [CW-1:0]   in_r, in_g, in_b, out_s, out_v;
   logic [TAGW-1:0] in_tag, out_tag;
   logic [HW-1:0]   out_h;
   int              n_chk = 0;
   int              n_err = 0;
`ifdef HSV_THRESH_EN
   logic [HW-1:0]   th_h_lo = 0;
   logic [HW-1:0]   th_h_hi = 191;
   logic [CW-1:0]   th_s_min = 0;
   logic [CW-1:0]   th_v_min = 0;
   logic            out_mask;
`endif

   rgb2hsv_seq #(.CW(CW), .HFRAC(HFRAC), .TAGW(TAGW)) dut (
      .Sys_clk  (Sys_clk),
      .resetx   (resetx),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_r     (in_r),
      .in_g     (in_g),
      .in_b     (in_b),
      .in_tag   (in_tag),
`ifdef HSV_THRESH_EN
      .th_h_lo  (th_h_lo),
      .th_h_hi  (th_h_hi),
      .th_s_min (th_s_min),
      .th_v_min (th_v_min),
      .out_mask (out_mask),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_h    (out_h),
      .out_s    (out_s),
      .out_v    (out_v),
      .out_tag  (out_tag)
   );

   initial Sys_clk = 1'b0;
   always #5 Sys_clk = ~Sys_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // HSV from first principles: ranked channels, tie priorities, sector table, integer division
   task automatic model(input int r, input int g, input int b, output int h, output int s, output int v);
      int c[3];
      int pmax[3];
      int pmin[3];
      int mx, mn, imax, imin, imid, d, qh, k, one;
      c[0] = r; c[1] = g; c[2] = b;
      pmax = '{0, 1, 2};
      pmin = '{2, 0, 1};
      mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
      mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
      imax = -1; imin = -1;
      for (int i = 0; i < 3; i++) begin
         if (imax < 0 && c[pmax[i]] == mx) imax = pmax[i];
         if (imin < 0 && c[pmin[i]] == mn) imin = pmin[i];
      end
      imid = 3 - imax - imin;
      d = mx - mn;
      one = 1 << HFRAC;
      v = mx;
      s = (mx == 0) ? 0 : (d * (1 << CW)) / mx;
      if (s > (1 << CW) - 1) s = (1 << CW) - 1;
      case (imax * 3 + imin)
         2: k = 0;
         5: k = 1;
         3: k = 2;
         6: k = 3;
         7: k = 4;
         1: k = 5;
         default: k = 0;
      endcase
      qh = (d == 0) ? 0 : ((c[imid] - mn) * one) / d;
      h = (k % 2 == 0) ? k * one + qh : (k + 1) * one - qh;
      if (h == 6 * one) h = 0;
   endtask

   task automatic start(input int r, input int g, input int b, input int tag);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(negedge Sys_clk);
         n++;
      end
      chk("start_ready", in_ready, 1);
      in_r = r[CW-1:0]; in_g = g[CW-1:0]; in_b = b[CW-1:0]; in_tag = tag[TAGW-1:0];
      in_valid = 1'b1;
      @(posedge Sys_clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic result(input int eh, input int es, input int ev, input int etag, input int hold);
      int lat = 0;
`ifdef HSV_THRESH_EN
      int hin, em;
      if (int'(th_h_lo) <= int'(th_h_hi)) hin = (eh >= int'(th_h_lo) && eh <= int'(th_h_hi)) ? 1 : 0;
      else                                hin = (eh >= int'(th_h_lo) || eh <= int'(th_h_hi)) ? 1 : 0;
      em = (hin == 1 && es >= int'(th_s_min) && ev >= int'(th_v_min)) ? 1 : 0;
`endif
      do begin
         @(negedge Sys_clk);
         lat++;
         if (lat == 1) chk("busy_in_ready", in_ready, 0);
      end while (!out_valid && lat < 60);
      chk("latency", lat, LAT);
      for (int i = 0; i <= hold; i++) begin
         chk("out_valid", out_valid, 1);
         chk("in_ready_done", in_ready, 0);
         chk("out_h", out_h, eh);
         chk("out_s", out_s, es);
         chk("out_v", out_v, ev);
         chk("out_tag", out_tag, etag);
`ifdef HSV_THRESH_EN
         chk("out_mask", out_mask, em);
`endif
         if (i < hold) @(negedge Sys_clk);
      end
      out_ready = 1'b1;
      @(negedge Sys_clk);
      out_ready = 1'b0;
      chk("xfer_valid", out_valid, 0);
      chk("xfer_ready", in_ready, 1);
   endtask

   initial begin
      int h, s, v, h2, s2, v2, n;
      resetx = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_r = '0; in_g = '0; in_b = '0; in_tag = '0;
      repeat (3) @(negedge Sys_clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_h", out_h, 0);
      chk("rst_out_s", out_s, 0);
      chk("rst_out_v", out_v, 0);
      chk("rst_out_tag", out_tag, 0);
      resetx = 1'b1;
      @(negedge Sys_clk);

      start(255, 0, 0, 'h1234);   result(0, 255, 255, 'h1234, 0);
      start(0, 255, 0, 1);        result(64, 255, 255, 1, 2);
      start(100, 100, 100, 2);    result(0, 0, 100, 2, 0);
      start(0, 0, 0, 3);          result(0, 0, 0, 3, 0);
      start(200, 150, 100, 4);    result(16, 128, 200, 4, 1);
      start(255, 0, 128, 5);      result(176, 255, 255, 5, 0);

      // backpressure: a second pixel waits on in_valid until the first one transfers
      model(10, 200, 30, h, s, v);
      model(30, 60, 240, h2, s2, v2);
      start(10, 200, 30, 'h00aa);
      in_r = 30; in_g = 60; in_b = 240; in_tag = 'h00bb; in_valid = 1'b1;
      result(h, s, v, 'h00aa, 10);
      @(posedge Sys_clk);
      #1 in_valid = 1'b0;
      result(h2, s2, v2, 'h00bb, 0);

      // reset during the saturation divide aborts the pixel
      start(255, 0, 0, 7);
      repeat (4) @(negedge Sys_clk);
      resetx = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_v", out_v, 0);
      @(negedge Sys_clk);
      resetx = 1'b1;
      @(negedge Sys_clk);
      start(200, 150, 100, 8);    result(16, 128, 200, 8, 0);

      // throughput with out_ready held high
      out_ready = 1'b1;
      in_r = 50; in_g = 60; in_b = 70; in_tag = 9; in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge Sys_clk);
         n++;
      end while (!in_ready && n < 100);
      in_valid = 1'b0;
      chk("period", n, PERIOD);
      out_ready = 1'b0;
      @(negedge Sys_clk);

      for (int i = 0; i < 40; i++) begin
         int r, g, b, mode;
         r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
         mode = $urandom_range(0, 3);
         if (mode == 1) g = r;
         if (mode == 2) begin g = r; b = r; end
         if (mode == 3) begin r = $urandom_range(0, 3); g = $urandom_range(0, 3); b = $urandom_range(0, 3); end
         model(r, g, b, h, s, v);
         start(r, g, b, i + 100);
         result(h, s, v, i + 100, $urandom_range(0, 2));
      end

`ifdef HSV_THRESH_EN
      th_h_lo = 180; th_h_hi = 10; th_s_min = 100; th_v_min = 50;
      start(255, 0, 0, 20);       result(0, 255, 255, 20, 0);
      start(255, 0, 128, 21);     result(176, 255, 255, 21, 0);
      start(100, 100, 100, 22);   result(0, 0, 100, 22, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
